fibo_bcd_conv: RTL and testbench
================================

FIBO_BCD_CONV -- requirements
Module: fibo_bcd_conv

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-003 SHALL have port: Fibo_out  input  16  unsigned binary value from the Fibonacci generator stage.
REQ-004 SHALL have port: Fibo_valid  input  1  one-cycle qualifier for Fibo_out; the value is sampled on the edge where this is high.
REQ-005 SHALL have port: bcd_out  output  20  five packed BCD digits; [19:16] is ten-thousands, [3:0] is units.
REQ-006 SHALL have port: bcd_valid  output  1  one-cycle pulse marking a new bcd_out.
REQ-007 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port: drop_cnt  output  8  saturating count of inputs lost because the block was busy and the hold register was full.

Function
REQ-009 SHALL implement an FSM with states IDLE, SHIFT and DONE; busy is decoded from the registered state.
REQ-010 SHALL convert using sequential double-dabble: per SHIFT cycle, add 3 to each BCD nibble that is >=5, then shift the {BCD, binary} register left by 1.
REQ-011 SHALL, in IDLE with Fibo_valid=1 at edge k: load Fibo_out into the binary field, clear the BCD field, clear the iteration counter, and go to SHIFT.
REQ-012 SHALL perform exactly 16 iterations on edges k+1..k+16, then enter DONE at edge k+16.
REQ-013 SHALL, at edge k+17 (DONE), register the result into bcd_out and drive bcd_valid=1 for exactly that one cycle; latency is 17 cycles from the sampling edge.
REQ-014 SHALL hold bcd_out at its last value until the next result; bcd_valid SHALL be 0 at all other times.
REQ-015 SHALL provide a one-entry hold register (16-bit value plus full flag).
REQ-016 SHALL, on Fibo_valid=1 in SHIFT with the hold register empty, store Fibo_out in it and set full.
REQ-017 SHALL, on Fibo_valid=1 in SHIFT with the hold register full, discard the input, keep the held value, and increment drop_cnt (saturating at 255).
REQ-018 SHALL resolve the DONE exit edge as follows:
- hold full: load the held value, go to SHIFT; hold <= Fibo_out (full) if Fibo_valid=1, else hold <= empty.
- hold empty, Fibo_valid=1: load Fibo_out directly, go to SHIFT.
- otherwise: go to IDLE.
REQ-019 SHALL never drop an input arriving in IDLE or DONE.
REQ-020 SHALL keep all arithmetic at unsigned widths: 36-bit working register, 5-bit iteration counter, 4-bit nibble add-3 with no carry between nibbles; the maximum value 65535 fits without overflow.

Reset
REQ-021 SHALL, while reset=0: state=IDLE, bcd_out=20'h00000, bcd_valid=0, busy=0, drop_cnt=0, hold empty, working register and counter zero.
REQ-022 SHALL abandon any in-flight conversion and held value when reset asserts mid-operation; no bcd_valid pulse SHALL follow the release.
REQ-023 SHALL treat the first edge after reset release as a normal IDLE edge; Fibo_valid high on that edge is accepted.

Verification
REQ-024 SHALL cover: Fibo_out=16'd8 with Fibo_valid at edge k -> bcd_out=20'h00008, bcd_valid pulse at edge k+17, busy high from k to k+17.
REQ-025 SHALL cover: Fibo_out=16'd65535 -> bcd_out=20'h65535; Fibo_out=0 -> bcd_out=20'h00000 with bcd_valid still pulsed.
REQ-026 SHALL cover: 13 at edge k, 21 at edge k+5 -> 20'h00013 valid at k+17, 20'h00021 valid at k+34, drop_cnt=0.
REQ-027 SHALL cover: 5 at k, 8 at k+3, 13 at k+6 -> results 20'h00005 and 20'h00008 only, drop_cnt=1.
REQ-028 SHALL cover: reset low for 1 cycle at k+8 mid-conversion -> all outputs zero immediately, no bcd_valid; a new input of 21 after release -> 20'h00021 after 17 cycles.
REQ-029 SHALL cover: 300 dropped inputs -> drop_cnt stays at 255.

Source files
------------

// File: rtl/fibo_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble) for the Fibonacci stage.
// A one-entry hold register absorbs one input arriving mid-conversion; further arrivals are counted as drops.
module fibo_bcd_conv (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Fibo_out,
    input  logic        Fibo_valid,
    output logic [19:0] bcd_out,
    output logic        bcd_valid,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [35:0] work;
    logic [4:0]  iter;
    logic [15:0] hold_val;
    logic        hold_full;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Each BCD nibble is corrected on its own (no carry between nibbles), then {BCD, binary} shifts left.
    function automatic logic [35:0] dabble_step(input logic [35:0] w);
        logic [35:0] a;
        a = w;
        for (int i = 0; i < 5; i++) begin
            a[16 + 4*i +: 4] = add3(w[16 + 4*i +: 4]);
        end
        return a << 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            iter      <= '0;
            hold_val  <= '0;
            hold_full <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Fibo_valid) begin
                        work  <= {20'd0, Fibo_out};
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= dabble_step(work);
                    iter <= iter + 5'd1;
                    if (iter == 5'd15) begin
                        state <= DONE;
                    end
                    if (Fibo_valid) begin
                        if (!hold_full) begin
                            hold_val  <= Fibo_out;
                            hold_full <= 1'b1;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end
                DONE: begin
                    bcd_out   <= work[35:16];
                    bcd_valid <= 1'b1;
                    // The held value takes priority; a same-edge arrival refills the hold slot.
                    if (hold_full) begin
                        work  <= {20'd0, hold_val};
                        iter  <= '0;
                        state <= SHIFT;
                        if (Fibo_valid) begin
                            hold_val <= Fibo_out;
                        end else begin
                            hold_full <= 1'b0;
                        end
                    end else if (Fibo_valid) begin
                        work  <= {20'd0, Fibo_out};
                        iter  <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_bcd_conv.sv
// Self-checking bench for fibo_bcd_conv: vector table plus hand-built overlap, reset and saturation sequences.
// Expected results are queued when an input is driven and checked when bcd_valid pulses.
module tb_fibo_bcd_conv;

    logic        clk;
    logic        reset;
    logic [15:0] Fibo_out;
    logic        Fibo_valid;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  drop_cnt;

    fibo_bcd_conv dut (
        .clk        (clk),
        .reset      (reset),
        .Fibo_out   (Fibo_out),
        .Fibo_valid (Fibo_valid),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic [15:0] v;
        logic [19:0] bcd;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        int          cyc;
    } sb_t;

    vec_t tbl [11];
    sb_t  exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic free_run = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Outputs are observed on the falling edge, half a cycle after they update.
    always @(negedge clk) begin
        if (reset && bcd_valid) begin
            if (free_run) begin
                check("free_run_bcd", 32'(bcd_out), 32'h00007);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got bcd_out=%0h, required no pulse (cycle %0d)", bcd_out, cyc);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a falling edge: the value is sampled on the next rising edge (edge k = cyc+1).
    task automatic drive(input logic [15:0] v, input logic [19:0] bcd, input int off);
        sb_t e;
        Fibo_out   = v;
        Fibo_valid = 1'b1;
        if (off > 0) begin
            e.bcd = bcd;
            e.cyc = cyc + 1 + off;
            exp_q.push_back(e);
        end
        @(negedge clk);
        Fibo_valid = 1'b0;
    endtask

    task automatic run_single(input logic [15:0] v, input logic [19:0] bcd);
        int hi;
        hi = 0;
        drive(v, bcd, 17);
        repeat (17) begin
            if (busy) hi++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(hi), 32'd17);
        check("busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("bcd_hold", 32'(bcd_out), 32'(bcd));
        check("valid_one_cycle", 32'(bcd_valid), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{16'd8,     20'h00008};
        tbl[1]  = '{16'd65535, 20'h65535};
        tbl[2]  = '{16'd0,     20'h00000};
        tbl[3]  = '{16'd1,     20'h00001};
        tbl[4]  = '{16'd9,     20'h00009};
        tbl[5]  = '{16'd10,    20'h00010};
        tbl[6]  = '{16'd99,    20'h00099};
        tbl[7]  = '{16'd1000,  20'h01000};
        tbl[8]  = '{16'd12345, 20'h12345};
        tbl[9]  = '{16'd46368, 20'h46368};
        tbl[10] = '{16'd59999, 20'h59999};

        reset      = 1'b0;
        Fibo_valid = 1'b0;
        Fibo_out   = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_bcd_out", 32'(bcd_out), 32'd0);
        check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Input present on the very first edge after release must be taken.
        reset = 1'b1;
        run_single(16'd8, 20'h00008);

        for (int i = 0; i < 11; i++) begin
            run_single(tbl[i].v, tbl[i].bcd);
            repeat (2) @(negedge clk);
        end

        // 13 at k, 21 at k+5 (held) -> outputs at k+17 and k+34
        drive(16'd13, 20'h00013, 17);
        repeat (4) @(negedge clk);
        drive(16'd21, 20'h00021, 29);
        repeat (40) @(negedge clk);
        check("overlap_drop_cnt", 32'(drop_cnt), 32'd0);

        // Arrival exactly on the DONE edge with hold empty is loaded directly
        drive(16'd13, 20'h00013, 17);
        repeat (16) @(negedge clk);
        drive(16'd21, 20'h00021, 17);
        repeat (25) @(negedge clk);
        check("done_load_drop_cnt", 32'(drop_cnt), 32'd0);
        check("done_load_busy", 32'(busy), 32'd0);

        // Hold full and a new arrival on the DONE edge: held value runs, new one refills hold
        drive(16'd5, 20'h00005, 17);
        repeat (2) @(negedge clk);
        drive(16'd8, 20'h00008, 31);
        repeat (13) @(negedge clk);
        drive(16'd9, 20'h00009, 34);
        repeat (45) @(negedge clk);
        check("refill_drop_cnt", 32'(drop_cnt), 32'd0);

        // 5 at k, 8 at k+3, 13 at k+6 -> 13 is dropped
        drive(16'd5, 20'h00005, 17);
        repeat (2) @(negedge clk);
        drive(16'd8, 20'h00008, 31);
        repeat (2) @(negedge clk);
        drive(16'd13, 20'h00000, 0);
        repeat (40) @(negedge clk);
        check("drop_one", 32'(drop_cnt), 32'd1);

        // Reset mid-conversion abandons work; no pulse may follow
        drive(16'd99, 20'h00000, 0);
        repeat (7) @(negedge clk);
        check("mid_conv_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_bcd_out", 32'(bcd_out), 32'd0);
        check("async_rst_bcd_valid", 32'(bcd_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("post_rst_bcd_out", 32'(bcd_out), 32'd0);
        run_single(16'd21, 20'h00021);

        // Continuous input for 360 cycles: well over 255 drops
        free_run   = 1'b1;
        Fibo_out   = 16'd7;
        Fibo_valid = 1'b1;
        repeat (360) @(negedge clk);
        Fibo_valid = 1'b0;
        repeat (60) @(negedge clk);
        free_run = 1'b0;
        check("drop_saturated", 32'(drop_cnt), 32'd255);
        check("drained_busy", 32'(busy), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
